// File: rtl/lcd_pkg.sv
// Shared constants and state encodings for the HD44780 16x2 LCD controller.
package lcd_pkg;

    localparam logic [7:0] CMD_FUNC_SET = 8'h38;
    localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
    localparam logic [7:0] CMD_CLEAR    = 8'h01;
    localparam logic [7:0] CMD_ENTRY    = 8'h06;
    localparam logic [7:0] CMD_LINE1    = 8'h80;
    localparam logic [7:0] CMD_LINE2    = 8'hC0;
    localparam logic [7:0] ASCII_SPACE  = 8'h20;

    typedef enum logic [2:0] {
        PWRUP,
        INIT,
        L1_ADDR,
        L1_CHAR,
        L2_ADDR,
        L2_CHAR
    } state_t;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        PULSE,
        WAIT
    } phase_t;

    // One spare bit so a counter can hold the largest timing value itself.
    function automatic int cnt_width(input int a, input int b, input int c,
                                     input int d, input int e);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        if (e > m) m = e;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/lcd_byte_writer.sv
// Sends one byte to the LCD bus: setup, enable pulse, then a fixed post-strobe wait.
module lcd_byte_writer
    import lcd_pkg::*;
#(
    parameter int SETUP_CYC    = 2,
    parameter int EN_CYC       = 25,
    parameter int WAIT_CYC     = 2500,
    parameter int CLR_WAIT_CYC = 100000,
    parameter int CNT_W        = 18
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       rs,
    input  logic [7:0] data,
    input  logic       long_wait,
    output logic       lcd_en,
    output logic       lcd_rs,
    output logic [7:0] lcd_data,
    output logic       done
);

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] EN_LAST    = CNT_W'(EN_CYC - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] CLR_LAST   = CNT_W'(CLR_WAIT_CYC - 1);

    phase_t           phase, phase_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             rs_q;
    logic [7:0]       data_q;
    logic             long_q;
    logic [CNT_W-1:0] wait_last;
    logic             launch;

    assign launch    = (phase == IDLE) && start;
    assign wait_last = long_q ? CLR_LAST : WAIT_LAST;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase  <= IDLE;
            cnt    <= '0;
            rs_q   <= 1'b0;
            data_q <= 8'h00;
            long_q <= 1'b0;
        end else begin
            phase <= phase_nxt;
            cnt   <= cnt_nxt;
            if (launch) begin
                rs_q   <= rs;
                data_q <= data;
                long_q <= long_wait;
            end
        end
    end

    // The start cycle itself counts as the first setup cycle.
    always_comb begin
        phase_nxt = phase;
        cnt_nxt   = cnt;
        case (phase)
            IDLE: begin
                if (start) begin
                    if (SETUP_CYC > 1) begin
                        phase_nxt = SETUP;
                        cnt_nxt   = CNT_W'(1);
                    end else begin
                        phase_nxt = PULSE;
                        cnt_nxt   = '0;
                    end
                end
            end
            SETUP: begin
                if (cnt == SETUP_LAST) begin
                    phase_nxt = PULSE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            PULSE: begin
                if (cnt == EN_LAST) begin
                    phase_nxt = WAIT;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            WAIT: begin
                if (cnt == wait_last) begin
                    phase_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                phase_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Bypass in the start cycle so the bus carries the byte from cycle t onward.
    assign lcd_rs   = launch ? rs   : rs_q;
    assign lcd_data = launch ? data : data_q;
    assign lcd_en   = (phase == PULSE);
    assign done     = (phase == WAIT) && (cnt == wait_last);

endmodule

// File: rtl/lcd_hd44780_ctrl.sv
// HD44780 16x2 controller: power-up wait, init commands, then endless refresh
// of both lines from a host-writable 32-character buffer.
module lcd_hd44780_ctrl
    import lcd_pkg::*;
#(
    parameter int POWERUP_CYC  = 750000,
    parameter int SETUP_CYC    = 2,
    parameter int EN_CYC       = 25,
    parameter int WAIT_CYC     = 2500,
    parameter int CLR_WAIT_CYC = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [4:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic       init_done,
    output logic       frame_done,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic       lcd_on
);

    localparam int CNT_W = cnt_width(POWERUP_CYC, SETUP_CYC, EN_CYC, WAIT_CYC, CLR_WAIT_CYC);
    localparam logic [CNT_W-1:0] PWRUP_LAST = CNT_W'(POWERUP_CYC - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] pwr_cnt, pwr_cnt_nxt;
    logic [1:0]       init_idx, init_idx_nxt;
    logic [3:0]       char_idx, char_idx_nxt;
    logic             start_q, start_nxt;
    logic             init_done_nxt, frame_done_nxt;
    logic [7:0]       char_buf [32];

    logic             byte_rs;
    logic [7:0]       byte_data;
    logic             byte_long;
    logic             byte_done;

    assign lcd_rw = 1'b0;

    // Host writes land in every state; a same-cycle read still sees the old byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) char_buf[i] <= ASCII_SPACE;
        end else if (wr_en) begin
            char_buf[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= PWRUP;
            pwr_cnt    <= '0;
            init_idx   <= '0;
            char_idx   <= '0;
            start_q    <= 1'b0;
            init_done  <= 1'b0;
            frame_done <= 1'b0;
            lcd_on     <= 1'b0;
        end else begin
            state      <= state_nxt;
            pwr_cnt    <= pwr_cnt_nxt;
            init_idx   <= init_idx_nxt;
            char_idx   <= char_idx_nxt;
            start_q    <= start_nxt;
            init_done  <= init_done_nxt;
            frame_done <= frame_done_nxt;
            lcd_on     <= 1'b1;
        end
    end

    // Each byte starts the cycle after the previous one's done.
    always_comb begin
        state_nxt      = state;
        pwr_cnt_nxt    = pwr_cnt;
        init_idx_nxt   = init_idx;
        char_idx_nxt   = char_idx;
        start_nxt      = 1'b0;
        init_done_nxt  = init_done;
        frame_done_nxt = 1'b0;
        case (state)
            PWRUP: begin
                if (pwr_cnt == PWRUP_LAST) begin
                    state_nxt    = INIT;
                    pwr_cnt_nxt  = '0;
                    init_idx_nxt = '0;
                    start_nxt    = 1'b1;
                end else begin
                    pwr_cnt_nxt = pwr_cnt + CNT_W'(1);
                end
            end
            INIT: begin
                if (byte_done) begin
                    start_nxt = 1'b1;
                    if (init_idx == 2'd3) begin
                        state_nxt     = L1_ADDR;
                        init_done_nxt = 1'b1;
                    end else begin
                        init_idx_nxt = init_idx + 2'd1;
                    end
                end
            end
            L1_ADDR: begin
                if (byte_done) begin
                    start_nxt    = 1'b1;
                    state_nxt    = L1_CHAR;
                    char_idx_nxt = '0;
                end
            end
            L1_CHAR: begin
                if (byte_done) begin
                    start_nxt = 1'b1;
                    if (char_idx == 4'd15) state_nxt = L2_ADDR;
                    else                   char_idx_nxt = char_idx + 4'd1;
                end
            end
            L2_ADDR: begin
                if (byte_done) begin
                    start_nxt    = 1'b1;
                    state_nxt    = L2_CHAR;
                    char_idx_nxt = '0;
                end
            end
            L2_CHAR: begin
                if (byte_done) begin
                    start_nxt = 1'b1;
                    if (char_idx == 4'd15) begin
                        state_nxt      = L1_ADDR;
                        frame_done_nxt = 1'b1;
                    end else begin
                        char_idx_nxt = char_idx + 4'd1;
                    end
                end
            end
            default: state_nxt = PWRUP;
        endcase
    end

    always_comb begin
        byte_rs   = 1'b0;
        byte_data = 8'h00;
        byte_long = 1'b0;
        case (state)
            INIT: begin
                case (init_idx)
                    2'd0:    byte_data = CMD_FUNC_SET;
                    2'd1:    byte_data = CMD_DISP_ON;
                    2'd2: begin
                        byte_data = CMD_CLEAR;
                        byte_long = 1'b1;
                    end
                    default: byte_data = CMD_ENTRY;
                endcase
            end
            L1_ADDR: byte_data = CMD_LINE1;
            L1_CHAR: begin
                byte_rs   = 1'b1;
                byte_data = char_buf[{1'b0, char_idx}];
            end
            L2_ADDR: byte_data = CMD_LINE2;
            L2_CHAR: begin
                byte_rs   = 1'b1;
                byte_data = char_buf[{1'b1, char_idx}];
            end
            default: ;
        endcase
    end

    lcd_byte_writer #(
        .SETUP_CYC    (SETUP_CYC),
        .EN_CYC       (EN_CYC),
        .WAIT_CYC     (WAIT_CYC),
        .CLR_WAIT_CYC (CLR_WAIT_CYC),
        .CNT_W        (CNT_W)
    ) u_writer (
        .clk       (clk),
        .rst       (rst),
        .start     (start_q),
        .rs        (byte_rs),
        .data      (byte_data),
        .long_wait (byte_long),
        .lcd_en    (lcd_en),
        .lcd_rs    (lcd_rs),
        .lcd_data  (lcd_data),
        .done      (byte_done)
    );

endmodule
